winograd_pre_transform_2d: RTL

Streaming 2D Winograd F(4x4,3x3) input-tile transform, V = B^T · d · B, for a 6x6 signed input tile. It sits upstream of the element-wise multiply stage and is the input-side counterpart of the output (A^T) transform. Tiles arrive one row per handshake; transformed rows leave one row per handshake. Row and column passes share a single internal 6x6 buffer.

---
 rtl/winograd_pre_transform_2d.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/winograd_pre_transform_2d.sv
// Streaming Winograd F(4x4,3x3) input transform V = B^T * d * B on a 6x6 signed tile.
// Row pass on each accepted input row into a shared buffer, column pass on each emitted row.
module winograd_pre_transform_2d #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [IN_W-1:0]  in_row [0:5],
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_row [0:5],
    output logic [2:0]              out_row_idx,
    output logic                    out_last
);

    typedef enum logic {
        LOAD = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t                  state;
    logic [2:0]              load_cnt;
    logic signed [OUT_W-1:0] tbuf    [0:5][0:5];
    logic signed [OUT_W-1:0] ext     [0:5];
    logic signed [OUT_W-1:0] t_row   [0:5];
    logic signed [OUT_W-1:0] col_next[0:5];
    logic [2:0]              col_sel;
    logic                    in_hs;
    logic                    out_hs;

    // Dot product of B^T row i with x, shift-add only.
    function automatic logic signed [OUT_W-1:0] bt_dot(
        input logic [2:0]              i,
        input logic signed [OUT_W-1:0] x0,
        input logic signed [OUT_W-1:0] x1,
        input logic signed [OUT_W-1:0] x2,
        input logic signed [OUT_W-1:0] x3,
        input logic signed [OUT_W-1:0] x4,
        input logic signed [OUT_W-1:0] x5
    );
        logic signed [OUT_W-1:0] r;
        case (i)
            3'd0:    r = (x0 <<< 2) - ((x2 <<< 2) + x2) + x4;
            3'd1:    r = x3 + x4 - (x1 <<< 2) - (x2 <<< 2);
            3'd2:    r = (x1 <<< 2) - (x2 <<< 2) - x3 + x4;
            3'd3:    r = (x3 <<< 1) + x4 - (x1 <<< 1) - x2;
            3'd4:    r = (x1 <<< 1) - x2 - (x3 <<< 1) + x4;
            3'd5:    r = (x1 <<< 2) - ((x3 <<< 2) + x3) + x5;
            default: r = '0;
        endcase
        return r;
    endfunction

    assign in_hs  = (state == LOAD) && in_valid && in_ready;
    assign out_hs = (state == EMIT) && out_valid && out_ready;

    always_comb begin
        for (int j = 0; j < 6; j++) begin
            ext[j] = OUT_W'(in_row[j]);
        end
        for (int i = 0; i < 6; i++) begin
            t_row[i] = bt_dot(3'(i), ext[0], ext[1], ext[2], ext[3], ext[4], ext[5]);
        end
    end

    // Row 0 of B^T has a zero weight on buffer row 5, so the column pass for
    // output row 0 may read the buffer in the same cycle row 5 is being written.
    always_comb begin
        col_sel = (state == LOAD) ? 3'd0 : (out_row_idx + 3'd1);
        for (int j = 0; j < 6; j++) begin
            col_next[j] = bt_dot(col_sel, tbuf[0][j], tbuf[1][j], tbuf[2][j],
                                 tbuf[3][j], tbuf[4][j], tbuf[5][j]);
        end
    end

    // Buffer holds row-pass results only; it is deliberately not reset.
    always_ff @(posedge clk) begin
        if (!rst && in_hs) begin
            for (int i = 0; i < 6; i++) begin
                tbuf[load_cnt][i] <= t_row[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= LOAD;
            load_cnt    <= 3'd0;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            out_row_idx <= 3'd0;
            out_last    <= 1'b0;
            for (int j = 0; j < 6; j++) begin
                out_row[j] <= '0;
            end
        end else begin
            case (state)
                LOAD: begin
                    if (in_hs) begin
                        if (load_cnt == 3'd5) begin
                            load_cnt    <= 3'd0;
                            state       <= EMIT;
                            in_ready    <= 1'b0;
                            out_valid   <= 1'b1;
                            out_row_idx <= 3'd0;
                            out_last    <= 1'b0;
                            for (int j = 0; j < 6; j++) begin
                                out_row[j] <= col_next[j];
                            end
                        end else begin
                            load_cnt <= load_cnt + 3'd1;
                        end
                    end
                end
                EMIT: begin
                    if (out_hs) begin
                        if (out_row_idx == 3'd5) begin
                            state       <= LOAD;
                            in_ready    <= 1'b1;
                            out_valid   <= 1'b0;
                            out_last    <= 1'b0;
                            out_row_idx <= 3'd0;
                        end else begin
                            out_row_idx <= out_row_idx + 3'd1;
                            out_last    <= (out_row_idx == 3'd4);
                            for (int j = 0; j < 6; j++) begin
                                out_row[j] <= col_next[j];
                            end
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule
